// File: rtl/uart_rx_checker_pkg.sv
// Shared types and constants for the UART receive monitor.
package uart_tb_pkg;

  typedef enum logic [1:0] {PAR_NONE, PAR_EVEN, PAR_ODD} e_parity;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, REPORT} e_rx_state;

  localparam int C_OVERSAMPLE = 16;
  localparam int C_MID_SAMPLE = 7;

  function automatic e_parity to_parity(input logic [1:0] cfg);
    case (cfg)
      2'd1:    return PAR_EVEN;
      2'd2:    return PAR_ODD;
      default: return PAR_NONE;
    endcase
  endfunction

endpackage

// File: rtl/uart_rx_checker_if.sv
// Expected-word push channel and per-frame report bundle of the monitor.
interface uart_rx_checker_if #(
  parameter int DW = 8,
  parameter int CW = 16
);
  logic          i_exp_valid;
  logic [DW-1:0] i_exp_data;
  logic          o_exp_ready;
  logic          o_chk_valid;
  logic [DW-1:0] o_rx_data;
  logic          o_parity_err;
  logic          o_frame_err;
  logic          o_mismatch;
  logic          o_unexpected;
  logic [CW-1:0] o_match_cnt;
  logic [CW-1:0] o_err_cnt;

  modport master (
    output i_exp_valid, i_exp_data,
    input  o_exp_ready, o_chk_valid, o_rx_data, o_parity_err, o_frame_err,
           o_mismatch, o_unexpected, o_match_cnt, o_err_cnt
  );

  modport slave (
    input  i_exp_valid, i_exp_data,
    output o_exp_ready, o_chk_valid, o_rx_data, o_parity_err, o_frame_err,
           o_mismatch, o_unexpected, o_match_cnt, o_err_cnt
  );
endinterface

// File: rtl/uart_rx_checker_sync_fifo.sv
// Single-clock FIFO; a push while full is dropped even if a pop happens that cycle.
module tb_sync_fifo #(
  parameter int G_WIDTH = 8,
  parameter int G_DEPTH = 16,
  localparam int AW = $clog2(G_DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_push_valid,
  input  logic [G_WIDTH-1:0] i_push_data,
  output logic               o_push_ready,
  input  logic               i_pop,
  output logic [G_WIDTH-1:0] o_head,
  output logic               o_empty
);
  logic [G_WIDTH-1:0] mem_q [G_DEPTH];
  logic [AW-1:0]      wr_q, rd_q;
  logic [AW:0]        cnt_q;
  logic               push_ok, pop_ok;

  assign o_push_ready = (cnt_q != (AW+1)'(G_DEPTH));
  assign o_empty      = (cnt_q == '0);
  assign o_head       = mem_q[rd_q];
  assign push_ok      = i_push_valid && o_push_ready;
  assign pop_ok       = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_ok) wr_q <= wr_q + 1'b1;
      if (pop_ok)  rd_q <= rd_q + 1'b1;
      if (push_ok && !pop_ok)      cnt_q <= cnt_q + 1'b1;
      else if (pop_ok && !push_ok) cnt_q <= cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q] <= i_push_data;
  end

endmodule

// File: rtl/uart_rx_checker.sv
// 16x-oversampling UART receive monitor comparing each frame against a queue of expected words.
module uart_rx_checker
  import uart_tb_pkg::*;
#(
  parameter int G_DATA_WIDTH = 8,
  parameter int G_POLARITY   = 1,
  parameter int G_FIRST_BIT  = 0,
  parameter int G_EXP_DEPTH  = 16,
  parameter int G_DIV_WIDTH  = 16,
  parameter int G_CNT_WIDTH  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_rx,
  input  logic [G_DIV_WIDTH-1:0] cfg_baud_div,
  input  logic [1:0]             cfg_parity,
  input  logic                   cfg_stop2,
  uart_rx_checker_if.slave       chk
);
  localparam logic IDLE_LVL = (G_POLARITY != 0);

  typedef struct packed {
    logic [G_DATA_WIDTH-1:0] data;
    logic                    perr;
    logic                    ferr;
    logic                    mism;
    logic                    unexp;
  } stat_t;

  logic [1:0]              sync_q;
  logic                    rx_prev_q, rx_n;
  e_rx_state               state_q, state_d;
  logic [G_DIV_WIDTH-1:0]  div_q, div_cnt_q, div_cnt_d, reload;
  logic [3:0]              tick_q, tick_d, bit_q, bit_d;
  logic [G_DATA_WIDTH-1:0] shreg_q, shreg_d, fifo_head;
  e_parity                 par_q;
  logic                    stop2_q, perr_q, perr_d, ferr_q, ferr_d;
  stat_t                   stat_q, stat_d;
  logic [G_CNT_WIDTH-1:0]  match_q, err_q;
  logic                    tick, sample, start_det, fifo_empty, pop, any_err;

  // Line normalised so that idle reads as 1 regardless of polarity.
  assign rx_n      = sync_q[1] ~^ IDLE_LVL;
  assign start_det = (state_q == IDLE) && rx_prev_q && !rx_n;
  assign tick      = (state_q != IDLE) && (div_cnt_q == '0);
  assign reload    = (div_q == '0) ? '0 : div_q - 1'b1;
  assign sample    = tick && ((state_q == START) ? (tick_q == 4'(C_MID_SAMPLE))
                                                 : (tick_q == 4'(C_OVERSAMPLE - 1)));
  assign any_err   = stat_d.perr || stat_d.ferr || stat_d.mism || stat_d.unexp;

  always_comb begin
    state_d   = state_q;
    div_cnt_d = div_cnt_q;
    tick_d    = tick_q;
    bit_d     = bit_q;
    shreg_d   = shreg_q;
    perr_d    = perr_q;
    ferr_d    = ferr_q;
    stat_d    = stat_q;
    pop       = 1'b0;
    if (tick) begin
      div_cnt_d = reload;
      tick_d    = sample ? '0 : tick_q + 1'b1;
    end else if (state_q != IDLE) begin
      div_cnt_d = div_cnt_q - 1'b1;
    end
    case (state_q)
      IDLE: if (start_det) begin
        state_d   = START;
        div_cnt_d = '0;
        tick_d    = '0;
        bit_d     = '0;
        perr_d    = 1'b0;
        ferr_d    = 1'b0;
      end
      START: if (sample) state_d = rx_n ? IDLE : DATA;
      DATA: if (sample) begin
        shreg_d = (G_FIRST_BIT != 0) ? {shreg_q[G_DATA_WIDTH-2:0], rx_n}
                                     : {rx_n, shreg_q[G_DATA_WIDTH-1:1]};
        bit_d   = bit_q + 1'b1;
        if (bit_q == 4'(G_DATA_WIDTH - 1)) begin
          bit_d   = '0;
          state_d = (par_q == PAR_NONE) ? STOP : PARITY;
        end
      end
      PARITY: if (sample) begin
        perr_d  = (^shreg_q) ^ rx_n ^ (par_q == PAR_ODD);
        state_d = STOP;
      end
      STOP: if (sample) begin
        if (!rx_n) ferr_d = 1'b1;
        bit_d = bit_q + 1'b1;
        if (bit_q == 4'(stop2_q)) state_d = REPORT;
      end
      REPORT: begin
        state_d      = IDLE;
        pop          = !fifo_empty;
        stat_d.data  = shreg_q;
        stat_d.perr  = perr_q;
        stat_d.ferr  = ferr_q;
        stat_d.unexp = fifo_empty;
        stat_d.mism  = !fifo_empty && (fifo_head != shreg_q);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q    <= {2{IDLE_LVL}};
      rx_prev_q <= 1'b1;
      state_q   <= IDLE;
      div_cnt_q <= '0;
      tick_q    <= '0;
      bit_q     <= '0;
      shreg_q   <= '0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      stat_q    <= '0;
      div_q     <= '0;
      par_q     <= PAR_NONE;
      stop2_q   <= 1'b0;
      match_q   <= '0;
      err_q     <= '0;
    end else begin
      sync_q    <= {sync_q[0], i_rx};
      rx_prev_q <= rx_n;
      state_q   <= state_d;
      div_cnt_q <= div_cnt_d;
      tick_q    <= tick_d;
      bit_q     <= bit_d;
      shreg_q   <= shreg_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      stat_q    <= stat_d;
      if (start_det) begin
        div_q   <= cfg_baud_div;
        par_q   <= to_parity(cfg_parity);
        stop2_q <= cfg_stop2;
      end
      if (state_q == REPORT) begin
        if (any_err) begin
          if (!(&err_q)) err_q <= err_q + 1'b1;
        end else if (!(&match_q)) begin
          match_q <= match_q + 1'b1;
        end
      end
    end
  end

  tb_sync_fifo #(.G_WIDTH(G_DATA_WIDTH), .G_DEPTH(G_EXP_DEPTH)) u_exp_fifo (
    .clk          (clk),
    .rst          (rst),
    .i_push_valid (chk.i_exp_valid),
    .i_push_data  (chk.i_exp_data),
    .o_push_ready (chk.o_exp_ready),
    .i_pop        (pop),
    .o_head       (fifo_head),
    .o_empty      (fifo_empty)
  );

  // Outside REPORT stat_d equals the held stat_q, so the flags persist until the next frame.
  assign chk.o_chk_valid  = (state_q == REPORT);
  assign chk.o_rx_data    = stat_d.data;
  assign chk.o_parity_err = stat_d.perr;
  assign chk.o_frame_err  = stat_d.ferr;
  assign chk.o_mismatch   = stat_d.mism;
  assign chk.o_unexpected = stat_d.unexp;
  assign chk.o_match_cnt  = match_q;
  assign chk.o_err_cnt    = err_q;

endmodule

// File: doc/uart_rx_checker.md
Name: uart_rx_checker

Overview:
Parametrised, self-checking UART receive monitor for testbenches. It oversamples one serial line at 16x with a runtime baud divisor and decodes frames with runtime-selectable parity and stop-bit count. Each received word is compared against an expected-data FIFO loaded by the sequencer, and the block reports per-frame status and running pass/error counters. It sits next to the UART DUT pins in lib_tb_uart and is instantiated once per monitored line.

Parameters:
G_DATA_WIDTH, 8, data bits per frame (5..9)
G_POLARITY, 1, line idle level (1: idle high, start bit low)
G_FIRST_BIT, 0, 0: LSB first, 1: MSB first
G_EXP_DEPTH, 16, expected-data FIFO depth (power of 2, >=2)
G_DIV_WIDTH, 16, width of cfg_baud_div
G_CNT_WIDTH, 16, width of match/error counters

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active high
i_rx  in  1  asynchronous serial line
cfg_baud_div  in  G_DIV_WIDTH  clk cycles per 16x tick; 0 is treated as 1
cfg_parity  in  2  0 none, 1 even, 2 odd, 3 none
cfg_stop2  in  1  0: one stop bit, 1: two stop bits
i_exp_valid  in  1  push expected word
i_exp_data  in  G_DATA_WIDTH  expected word
o_exp_ready  out  1  expected FIFO not full
o_chk_valid  out  1  one-cycle pulse per completed frame
o_rx_data  out  G_DATA_WIDTH  received word, valid with o_chk_valid
o_parity_err  out  1  parity mismatch, valid with o_chk_valid
o_frame_err  out  1  a stop bit was sampled at the non-idle level
o_mismatch  out  1  data differs from the expected word
o_unexpected  out  1  frame arrived while the expected FIFO was empty
o_match_cnt  out  G_CNT_WIDTH  frames with no error flag set; saturating
o_err_cnt  out  G_CNT_WIDTH  frames with any error flag set; saturating

Behaviour:
- Reset: all outputs 0 except o_exp_ready=1. FSM returns to IDLE, FIFO is emptied, counters are cleared, and the synchroniser is loaded with the idle level. Reset mid-frame abandons the frame with no o_chk_valid.
- i_rx passes through a 2-flop synchroniser (2 clk latency). Polarity is normalised internally so that idle=1.
- Tick generator: a counter reloads at max(cfg_baud_div,1)-1. One tick per reload, so a bit lasts 16 ticks. It runs only outside IDLE and is cleared on start detection.
- On start detection, cfg_parity, cfg_stop2 and cfg_baud_div are latched. Config changes mid-frame do not affect the current frame.
- FSM:
  - IDLE: a falling edge on the normalised line goes to START.
  - START: sample at tick 7. If the line is high (glitch), return to IDLE silently. Otherwise go to DATA.
  - DATA: sample every 16 ticks, G_DATA_WIDTH bits in G_FIRST_BIT order. Then go to PARITY if enabled, else STOP.
  - PARITY: one sample. Error if the data XOR parity bit is 1 for even, or 0 for odd.
  - STOP: 1 or 2 samples. Any sample at 0 sets frame_err. After the last stop sample, go to REPORT.
  - REPORT: one cycle, then IDLE. IDLE re-arms immediately, so back-to-back frames are supported.
- REPORT cycle outputs:
  - o_chk_valid=1, o_rx_data and the status flags are updated and held until the next report.
  - The head of the expected FIFO is popped and compared under G_DATA_WIDTH width.
  - If the FIFO is empty: o_unexpected=1, o_mismatch=0, nothing is popped.
  - Frame with an error flag set: o_err_cnt++. Otherwise: o_match_cnt++. Both counters saturate at all-ones.
- Latency: o_chk_valid rises exactly 1 clk after the clk on which the final stop bit is sampled.
- FIFO:
  - o_exp_ready = !full.
  - A push while full is dropped, even when a pop happens in the same cycle.
  - Push and pop in the same cycle when not full: both take effect and the count is unchanged.
  - Push into an empty FIFO in the same cycle as REPORT: the compare sees empty (unexpected), and the pushed word remains queued.
  - Pointers wrap modulo G_EXP_DEPTH. The count is log2(G_EXP_DEPTH)+1 bits wide.

Decomposition:
- Package uart_tb_pkg holds:
  - typedef e_parity {PAR_NONE, PAR_EVEN, PAR_ODD}
  - typedef e_rx_state {IDLE, START, DATA, PARITY, STOP, REPORT}
  - localparam C_OVERSAMPLE=16 and C_MID_SAMPLE=7
- Sub-module tb_sync_fifo (parametrised width and depth, ready/valid push, pop with empty flag) implements the expected queue. The FSM, tick generator and compare logic stay in uart_rx_checker.

Test Plan:
1. Baseline frame: div=1, parity none, 1 stop. Push 0xA5, send 0xA5 LSB-first. Result: o_chk_valid 1 clk after the stop sample, o_rx_data=0xA5, all flags 0, match_cnt=1.
2. Parity error: even parity. Send 0x3C with parity bit 1. Result: o_parity_err=1, err_cnt=1. Then send 0x3C with parity bit 0 and expected 0x3C. Result: match_cnt=1.
3. Start glitch: a low pulse of 4 ticks (shorter than the 7-tick start sample). Result: no o_chk_valid and the FIFO count is unchanged. A following valid 0x55 decodes correctly.
4. Frame error and two stop bits: cfg_stop2=1, second stop bit driven 0 on byte 0x81. Result: o_frame_err=1, data still 0x81 and compared.
5. FIFO: push 17 words into G_EXP_DEPTH=16. Result: the 17th is dropped and o_exp_ready=0. Receive 16 frames, then a 17th. Result: the 17th reports o_unexpected=1.
6. Config and reset: change cfg_baud_div from 4 to 2 mid-frame. Result: the frame still decodes at div 4. Assert rst mid-frame. Result: no report, counters 0, o_exp_ready=1.
